// File: rtl/menu_niveles_param.sv
// ---------------------------------------------------------------------------
// MenuNivelesParam: main-menu / game-flow controller for the frogger top level.
//
// Walks the player through IDLE -> SELECT -> LOAD -> PLAY and handles the
// retry / win / lose screens. It keeps the selected level index and the lives
// counter, and fires a one-cycle level-load pulse towards the game blocks.
// Every output is decoded from registered state only (Moore).
//
// Ports
//   MS_CLOCK_50    in   1        system clock (50 MHz)
//   MS_RESET_N     in   1        asynchronous reset, active low
//   MS_START       in   1        start/confirm button (rising edge used)
//   MS_UP          in   1        menu up button (rising edge used)
//   MS_DOWN        in   1        menu down button (rising edge used)
//   MS_GANO        in   1        level won, from game logic (level, PLAY only)
//   MS_PERDIO      in   1        life lost, from game logic (level, PLAY only)
//   MS_ESTADO_OUT  out  3        screen code 000 IDLE .. 110 LOSE
//   MS_NVL_OUT     out  LVL_W    selected / current level index
//   MS_CN_OUT      out  1        level-load pulse, high only in LOAD
//   MS_VIDAS_OUT   out  LIVES_W  lives remaining
// ---------------------------------------------------------------------------
module menu_niveles_param #(
   parameter int unsigned NUM_LEVELS    = 4,
   parameter int unsigned LVL_W         = 2,
   parameter int unsigned MAX_LIVES     = 3,
   parameter int unsigned LIVES_W       = 2,
   parameter int unsigned AUTO_ADVANCE  = 1,
   parameter int unsigned RETRY_CYCLES  = 50000000,
   parameter int unsigned SCREEN_CYCLES = 250000000,
   parameter int unsigned TMR_W         = 28
) (
   input  logic               MS_CLOCK_50,
   input  logic               MS_RESET_N,
   input  logic               MS_START,
   input  logic               MS_UP,
   input  logic               MS_DOWN,
   input  logic               MS_GANO,
   input  logic               MS_PERDIO,
   output logic [2:0]         MS_ESTADO_OUT,
   output logic [LVL_W-1:0]   MS_NVL_OUT,
   output logic               MS_CN_OUT,
   output logic [LIVES_W-1:0] MS_VIDAS_OUT
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b000,
      ST_SELECT = 3'b001,
      ST_LOAD   = 3'b010,
      ST_PLAY   = 3'b011,
      ST_RETRY  = 3'b100,
      ST_WIN    = 3'b101,
      ST_LOSE   = 3'b110
   } state_t;

   localparam logic [LVL_W-1:0]   LAST_LVL     = LVL_W'(NUM_LEVELS - 1);
   localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(MAX_LIVES);
   localparam logic [LIVES_W-1:0] ONE_LIFE     = LIVES_W'(1);
   localparam logic [TMR_W-1:0]   RETRY_LAST   = TMR_W'(RETRY_CYCLES - 1);
   localparam bit                 SCREEN_TO_EN = (SCREEN_CYCLES != 0);
   // With the timeout disabled the compare value is irrelevant; zero keeps it defined.
   localparam logic [TMR_W-1:0]   SCREEN_LAST  = SCREEN_TO_EN ? TMR_W'(SCREEN_CYCLES - 1) : '0;
   localparam logic [TMR_W-1:0]   TMR_MAX      = '1;
   localparam bit                 ADVANCE_EN   = (AUTO_ADVANCE != 0);

   state_t               state_q, state_d;
   logic [LVL_W-1:0]     level_q, level_d;
   logic [LIVES_W-1:0]   lives_q, lives_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic                 startHist_q, upHist_q, downHist_q;

   logic                 evtStart, evtUp, evtDown;
   logic                 timedState;

   // Button rising-edge events. The history registers reset to 1 so that a
   // button already held while reset is released is not seen as a fresh press.
   always_comb begin
      evtStart = MS_START & ~startHist_q;
      evtUp    = MS_UP    & ~upHist_q;
      evtDown  = MS_DOWN  & ~downHist_q;
   end

   // State register plus the level, lives, timer and button-history registers.
   // Reset is asynchronous so pulling MS_RESET_N aborts a game immediately.
   always_ff @(posedge MS_CLOCK_50 or negedge MS_RESET_N) begin
      if (!MS_RESET_N) begin
         state_q     <= ST_IDLE;
         level_q     <= '0;
         lives_q     <= LIVES_INIT;
         timer_q     <= '0;
         startHist_q <= 1'b1;
         upHist_q    <= 1'b1;
         downHist_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         lives_q     <= lives_d;
         timer_q     <= timer_d;
         startHist_q <= MS_START;
         upHist_q    <= MS_UP;
         downHist_q  <= MS_DOWN;
      end
   end

   // Next-state logic. Simultaneous button events resolve START > DOWN > UP;
   // in PLAY a win beats a life lost in the same cycle. The timer measures
   // time spent on the current retry/win/lose screen: it restarts on every
   // screen change and saturates instead of wrapping, so a screen without a
   // timeout can sit there indefinitely without ever re-triggering.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      lives_d = lives_q;
      timer_d = '0;

      case (state_q)
         ST_IDLE: begin
            if (evtStart) begin
               state_d = ST_SELECT;
               level_d = '0;
            end
         end
         ST_SELECT: begin
            if (evtStart) begin
               state_d = ST_LOAD;
               lives_d = LIVES_INIT;
            end else if (evtDown) begin
               level_d = (level_q == LAST_LVL) ? '0 : level_q + 1'b1;
            end else if (evtUp) begin
               level_d = (level_q == '0) ? LAST_LVL : level_q - 1'b1;
            end
         end
         ST_LOAD: begin
            state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (MS_GANO) begin
               if (ADVANCE_EN && (level_q < LAST_LVL)) begin
                  state_d = ST_LOAD;
                  level_d = level_q + 1'b1;
               end else begin
                  state_d = ST_WIN;
               end
            end else if (MS_PERDIO) begin
               if (lives_q > ONE_LIFE) begin
                  state_d = ST_RETRY;
                  lives_d = lives_q - 1'b1;
               end else begin
                  state_d = ST_LOSE;
                  lives_d = '0;
               end
            end
         end
         ST_RETRY: begin
            if (timer_q == RETRY_LAST) begin
               state_d = ST_LOAD;
            end
         end
         ST_WIN, ST_LOSE: begin
            if (evtStart || (SCREEN_TO_EN && (timer_q == SCREEN_LAST))) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      timedState = (state_q == ST_RETRY) || (state_q == ST_WIN) || (state_q == ST_LOSE);
      if ((state_d == state_q) && timedState) begin
         timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
      end
   end

   // Output decode straight from the registered state. Any encoding outside
   // the seven screens shows as IDLE for the single cycle before recovery.
   always_comb begin
      MS_ESTADO_OUT = 3'b000;
      MS_CN_OUT     = 1'b0;
      case (state_q)
         ST_IDLE, ST_SELECT, ST_LOAD, ST_PLAY, ST_RETRY, ST_WIN, ST_LOSE: begin
            MS_ESTADO_OUT = state_q;
         end
         default: begin
            MS_ESTADO_OUT = 3'b000;
         end
      endcase
      MS_CN_OUT    = (state_q == ST_LOAD);
      MS_NVL_OUT   = level_q;
      MS_VIDAS_OUT = lives_q;
   end

endmodule

// File: tb/tb_menu_niveles_param.sv
// ---------------------------------------------------------------------------
// Testbench for menu_niveles_param.
//
// Two instances share one set of inputs:
//   u0: 4 levels, 3 lives, auto-advance, RETRY_CYCLES=4, SCREEN_CYCLES=8
//   u1: 3 levels, 2 lives, no auto-advance, RETRY_CYCLES=3, no screen timeout
// A rule-level reference model follows each instance and is compared on every
// falling clock edge, next to a table of hand-computed vectors for u0 and a
// few hand-written sequences for the multi-cycle corner cases.
// ---------------------------------------------------------------------------
module tb_menu_niveles_param;

   logic clk    = 1'b0;
   logic rst_n  = 1'b1;
   logic start  = 1'b0;
   logic up     = 1'b0;
   logic down   = 1'b0;
   logic gano   = 1'b0;
   logic perdio = 1'b0;

   logic [2:0] est0, est1;
   logic [1:0] nvl0, nvl1;
   logic       cn0, cn1;
   logic [1:0] vid0, vid1;
   logic [15:0] dut0, dut1;

   int total = 0;
   int bad   = 0;
   bit chkOn = 1'b0;

   always #5 clk = ~clk;

   menu_niveles_param #(
      .NUM_LEVELS(4), .LVL_W(2), .MAX_LIVES(3), .LIVES_W(2), .AUTO_ADVANCE(1),
      .RETRY_CYCLES(4), .SCREEN_CYCLES(8), .TMR_W(8)
   ) u0 (
      .MS_CLOCK_50(clk), .MS_RESET_N(rst_n), .MS_START(start), .MS_UP(up),
      .MS_DOWN(down), .MS_GANO(gano), .MS_PERDIO(perdio),
      .MS_ESTADO_OUT(est0), .MS_NVL_OUT(nvl0), .MS_CN_OUT(cn0), .MS_VIDAS_OUT(vid0)
   );

   menu_niveles_param #(
      .NUM_LEVELS(3), .LVL_W(2), .MAX_LIVES(2), .LIVES_W(2), .AUTO_ADVANCE(0),
      .RETRY_CYCLES(3), .SCREEN_CYCLES(0), .TMR_W(8)
   ) u1 (
      .MS_CLOCK_50(clk), .MS_RESET_N(rst_n), .MS_START(start), .MS_UP(up),
      .MS_DOWN(down), .MS_GANO(gano), .MS_PERDIO(perdio),
      .MS_ESTADO_OUT(est1), .MS_NVL_OUT(nvl1), .MS_CN_OUT(cn1), .MS_VIDAS_OUT(vid1)
   );

   assign dut0 = {8'd0, est0, nvl0, cn0, vid0};
   assign dut1 = {8'd0, est1, nvl1, cn1, vid1};

   // Reference model: the game flow as plain rules over integers.
   // scr is the screen number (0 IDLE .. 6 LOSE), t counts cycles already
   // spent on the current screen.
   typedef struct {
      int nLv;
      int maxL;
      int autoAdv;
      int retry;
      int scrn;
   } cfg_t;

   typedef struct {
      int scr;
      int lvl;
      int lives;
      int t;
      bit ps;
      bit pu;
      bit pd;
   } mdl_t;

   typedef struct {
      logic       st;
      logic       u;
      logic       d;
      logic       g;
      logic       p;
      int         cyc;
      logic [2:0] est;
      logic [1:0] nvl;
      logic       cn;
      logic [1:0] vid;
   } vec_t;

   cfg_t cfg0 = '{nLv: 4, maxL: 3, autoAdv: 1, retry: 4, scrn: 8};
   cfg_t cfg1 = '{nLv: 3, maxL: 2, autoAdv: 0, retry: 3, scrn: 0};
   mdl_t m0, m1;

   function automatic mdl_t modelReset(cfg_t c);
      mdl_t m;
      m.scr   = 0;
      m.lvl   = 0;
      m.lives = c.maxL;
      m.t     = 0;
      m.ps    = 1'b1;
      m.pu    = 1'b1;
      m.pd    = 1'b1;
      return m;
   endfunction

   function automatic mdl_t modelStep(mdl_t m, cfg_t c, bit st, bit u, bit d, bit g, bit p);
      mdl_t n = m;
      bit pressS = st && !m.ps;
      bit pressU = u && !m.pu;
      bit pressD = d && !m.pd;
      n.ps = st;
      n.pu = u;
      n.pd = d;
      case (m.scr)
         0: if (pressS) begin n.scr = 1; n.lvl = 0; end
         1: begin
            if (pressS) begin
               n.scr = 2;
               n.lives = c.maxL;
            end else if (pressD) n.lvl = (m.lvl + 1) % c.nLv;
            else if (pressU) n.lvl = (m.lvl + c.nLv - 1) % c.nLv;
         end
         2: n.scr = 3;
         3: begin
            if (g) begin
               if (c.autoAdv != 0 && m.lvl < c.nLv - 1) begin
                  n.scr = 2;
                  n.lvl = m.lvl + 1;
               end else n.scr = 5;
            end else if (p) begin
               if (m.lives > 1) begin
                  n.scr = 4;
                  n.lives = m.lives - 1;
               end else begin
                  n.scr = 6;
                  n.lives = 0;
               end
            end
         end
         4: if (m.t == c.retry - 1) n.scr = 2;
         default: if (pressS || (c.scrn != 0 && m.t == c.scrn - 1)) n.scr = 0;
      endcase
      if (n.scr != m.scr) n.t = 0;
      else if (m.scr >= 4) n.t = m.t + 1;
      else n.t = 0;
      return n;
   endfunction

   function automatic logic [15:0] modelPack(mdl_t m);
      return {8'd0, 3'(m.scr), 2'(m.lvl), (m.scr == 2), 2'(m.lives)};
   endfunction

   function automatic vec_t mk(bit st, bit u, bit d, bit g, bit p, int cyc,
                               int est, int nvl, int cn, int vid);
      vec_t v;
      v.st  = st;
      v.u   = u;
      v.d   = d;
      v.g   = g;
      v.p   = p;
      v.cyc = cyc;
      v.est = 3'(est);
      v.nvl = 2'(nvl);
      v.cn  = 1'(cn);
      v.vid = 2'(vid);
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      start  = v.st;
      up     = v.u;
      down   = v.d;
      gano   = v.g;
      perdio = v.p;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got est=%0d nvl=%0d cn=%0d vidas=%0d, want est=%0d nvl=%0d cn=%0d vidas=%0d",
                  name, act[7:5], act[4:3], act[2], act[1:0], exp[7:5], exp[4:3], exp[2], exp[1:0]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // The models advance on the same edges as the DUTs and reset with them.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0 <= modelReset(cfg0);
         m1 <= modelReset(cfg1);
      end else begin
         m0 <= modelStep(m0, cfg0, start, up, down, gano, perdio);
         m1 <= modelStep(m1, cfg1, start, up, down, gano, perdio);
      end
   end

   // Continuous model comparison, sampled away from the active edge.
   always @(negedge clk) begin
      if (chkOn) begin
         checkOutput("model u0", dut0, modelPack(m0));
         checkOutput("model u1", dut1, modelPack(m1));
      end
   end

   vec_t tbl[$];

   initial begin
      // Table of u0 vectors: inputs held for cyc cycles, outputs checked after each.
      //                 st u  d  g  p  cyc est nvl cn vid
      tbl.push_back(mk(1, 0, 0, 0, 0, 1,  0, 0, 0, 3));  // START held through reset: no edge
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 3));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 3));  // fresh press -> SELECT
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  1, 0, 0, 3));
      tbl.push_back(mk(0, 1, 0, 0, 0, 1,  1, 3, 0, 3));  // UP wraps 0 -> 3
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  1, 3, 0, 3));
      tbl.push_back(mk(0, 0, 1, 0, 0, 1,  1, 0, 0, 3));  // DOWN wraps 3 -> 0
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  1, 0, 0, 3));
      tbl.push_back(mk(0, 0, 1, 0, 0, 10, 1, 1, 0, 3));  // DOWN held: one step only
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  1, 1, 0, 3));
      tbl.push_back(mk(0, 0, 1, 0, 0, 1,  1, 2, 0, 3));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  1, 2, 0, 3));
      tbl.push_back(mk(1, 0, 1, 0, 0, 1,  2, 2, 1, 3));  // START beats DOWN -> LOAD
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  3, 2, 0, 3));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1,  4, 2, 0, 2));  // life lost -> RETRY
      tbl.push_back(mk(0, 0, 0, 0, 0, 3,  4, 2, 0, 2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  2, 2, 1, 2));  // reload after 4 RETRY cycles
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  3, 2, 0, 2));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1,  4, 2, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3,  4, 2, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  2, 2, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  3, 2, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1,  6, 2, 0, 0));  // last life -> LOSE
      tbl.push_back(mk(0, 0, 0, 0, 0, 7,  6, 2, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 2, 0, 0));  // LOSE times out after 8 cycles
      tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1,  2, 0, 1, 3));  // lives refilled on start
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  3, 0, 0, 3));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1,  4, 0, 0, 2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3,  4, 0, 0, 2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  2, 0, 1, 2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  3, 0, 0, 2));
      tbl.push_back(mk(0, 0, 0, 1, 1, 1,  2, 1, 1, 2));  // GANO beats PERDIO, lives kept
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  3, 1, 0, 2));
      tbl.push_back(mk(0, 0, 0, 1, 0, 1,  2, 2, 1, 2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  3, 2, 0, 2));
      tbl.push_back(mk(0, 0, 0, 1, 0, 1,  2, 3, 1, 2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  3, 3, 0, 2));
      tbl.push_back(mk(0, 0, 0, 1, 0, 1,  5, 3, 0, 2));  // win on final level -> WIN
      tbl.push_back(mk(0, 0, 0, 0, 0, 7,  5, 3, 0, 2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 3, 0, 2));  // WIN times out after 8 cycles

      // Reset with START held high across the release.
      start = 1'b1;
      #1 rst_n = 1'b0;
      #1 chkOn = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset state u0", dut0, {8'd0, 3'd0, 2'd0, 1'b0, 2'd3});
      checkOutput("reset state u1", dut1, {8'd0, 3'd0, 2'd0, 1'b0, 2'd2});
      #2 rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i]);
         for (int k = 0; k < tbl[i].cyc; k++) begin
            tick();
            checkOutput($sformatf("row %0d", i), dut0,
                        {8'd0, tbl[i].est, tbl[i].nvl, tbl[i].cn, tbl[i].vid});
         end
      end

      // Screen without timeout (u1) waits for START; u0 ignores START in PLAY.
      applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0)); tick();
      applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); tick();
      applyStimulus(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0)); tick();
      applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); tick();
      applyStimulus(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0)); tick();
      checkOutput("u1 win without advance", dut1, {8'd0, 3'd5, 2'd0, 1'b0, 2'd2});
      checkOutput("u0 advance to level 1", dut0, {8'd0, 3'd2, 2'd1, 1'b1, 2'd3});
      applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      repeat (20) tick();
      checkOutput("u1 no screen timeout", dut1, {8'd0, 3'd5, 2'd0, 1'b0, 2'd2});
      applyStimulus(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0)); tick();
      checkOutput("u1 start leaves WIN", dut1, {8'd0, 3'd0, 2'd0, 1'b0, 2'd2});
      checkOutput("u0 start ignored in PLAY", dut0, {8'd0, 3'd3, 2'd1, 1'b0, 2'd3});

      // Reset mid-game takes effect without waiting for a clock edge.
      #2 rst_n = 1'b0;
      #1 checkOutput("async reset mid-game", dut0, {8'd0, 3'd0, 2'd0, 1'b0, 2'd3});
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Randomised play against the model, with the odd reset thrown in.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start  = ($urandom_range(0, 3) == 0);
         up     = ($urandom_range(0, 3) == 0);
         down   = ($urandom_range(0, 3) == 0);
         gano   = ($urandom_range(0, 9) == 0);
         perdio = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 399) == 0) begin
            #2 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
      end

      @(negedge clk);
      chkOn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
